palette_lookup: RTL and testbench

//  Pixel-stream stage that turns 8-bit colour indices from the layer/composer path into 12-bit RGB444.
//  It does this by reading the 256x16 palette RAM through that RAM's read port.
//  It sits between the composer and the video output encoders.

---
 rtl/vera_video_pkg.sv | 32 +++
 rtl/rgb444_to_grey.sv | 30 +++
 rtl/palette_lookup.sv | 152 +++++++++++++++
 tb/tb_palette_lookup.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vera_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vera_video_pkg
// Description : Shared types and constants for the video pixel path.
//               rgb444_t  - 12-bit colour {r,g,b}, 4 bits per channel
//               pix_sb_t  - sideband carried with each pixel {hsync,vsync,blank}
//               LUMA_*    - integer luma weights; Y = (WR*R + WG*G + WB*B) >> SHIFT
// Revision    : 1.0 - initial release
// ============================================================================
package vera_video_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } pix_sb_t;

    // Weights sum to 16, so a full-scale input (15,15,15) gives 240 >> 4 = 15
    // and the 8-bit sum can never overflow.
    localparam int unsigned LUMA_WR    = 5;
    localparam int unsigned LUMA_WG    = 9;
    localparam int unsigned LUMA_WB    = 2;
    localparam int unsigned LUMA_SHIFT = 4;

endpackage
`default_nettype wire

// File: rtl/rgb444_to_grey.sv
`default_nettype none
// ============================================================================
// Module      : rgb444_to_grey
// Description : Combinational RGB444 -> 4-bit luma.
//               Y = (5*R + 9*G + 2*B) >> 4, result 0..15.
// Ports       : i_rgb  in   rgb444_t  colour to convert
//               o_y    out  4         grey level
// Revision    : 1.0 - initial release
// ============================================================================
module rgb444_to_grey
    import vera_video_pkg::*;
(
    input  rgb444_t    i_rgb,
    output logic [3:0] o_y
);

    logic [7:0] w_sum;
    logic       w_unused_low;

    assign w_sum = (8'(i_rgb.r) * 8'(LUMA_WR))
                 + (8'(i_rgb.g) * 8'(LUMA_WG))
                 + (8'(i_rgb.b) * 8'(LUMA_WB));

    assign o_y = w_sum[LUMA_SHIFT +: 4];

    // Fractional bits discarded by the shift.
    assign w_unused_low = &{1'b0, w_sum[LUMA_SHIFT-1:0]};

endmodule
`default_nettype wire

// File: rtl/palette_lookup.sv
`default_nettype none
// ============================================================================
// Module      : palette_lookup
// Description : Two-stage pixel pipeline converting 8-bit colour indices to
//               RGB444 through an external 256x16 palette RAM read port.
//               S1 registers the palette address and sideband; S2 registers
//               the final colour (border / chroma-disable / blank applied).
//               Full valid/ready back-pressure at 1 pixel per clock.
// Ports       : clk_i, rst_i (async, active high)
//               in_valid_i/in_ready_o, in_index_i, in_border_i, in_blank_i,
//               in_hsync_i, in_vsync_i          - upstream pixel stream
//               border_idx_i, chroma_disable_i  - quasi-static controls
//               pal_rd_addr_o, pal_rd_data_i    - palette RAM read port
//               out_valid_o/out_ready_i, out_r_o/out_g_o/out_b_o,
//               out_hsync_o, out_vsync_o, out_blank_o - downstream stream
// Revision    : 1.0 - initial release
// ============================================================================
module palette_lookup
    import vera_video_pkg::*;
#(
    parameter int RD_LATENCY = 1
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_index_i,
    input  logic        in_border_i,
    input  logic        in_blank_i,
    input  logic        in_hsync_i,
    input  logic        in_vsync_i,
    input  logic [7:0]  border_idx_i,
    input  logic        chroma_disable_i,
    output logic [7:0]  pal_rd_addr_o,
    input  logic [15:0] pal_rd_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  out_r_o,
    output logic [3:0]  out_g_o,
    output logic [3:0]  out_b_o,
    output logic        out_hsync_o,
    output logic        out_vsync_o,
    output logic        out_blank_o
);

    // Only a single-cycle palette read is supported by the stage timing.
    if (RD_LATENCY != 1) begin : g_rd_latency_check
        $error("palette_lookup: RD_LATENCY must be 1");
    end

    localparam pix_sb_t c_sb_idle = '{hsync: 1'b0, vsync: 1'b0, blank: 1'b1};

    // S1: address stage
    logic       r_s1_valid;
    logic [7:0] r_s1_addr;
    pix_sb_t    r_s1_sb;

    // Colour captured on the first stalled cycle so that palette writes to the
    // stalled entry during the stall cannot alter the pixel already in flight.
    rgb444_t    r_hold;
    logic       r_hold_full;

    // S2: output stage
    logic       r_out_valid;
    rgb444_t    r_out_rgb;
    pix_sb_t    r_out_sb;

    logic       w_s2_load;
    logic       w_accept;
    rgb444_t    w_src_rgb;
    rgb444_t    w_s2_rgb;
    logic [3:0] w_y;
    logic       w_unused_pal;

    assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready_i);
    // Combinational from out_ready_i so a draining output refills S1 the same cycle.
    assign in_ready_o = !r_s1_valid || w_s2_load;
    assign w_accept   = in_valid_i && in_ready_o;

    assign w_src_rgb  = r_hold_full ? r_hold : rgb444_t'(pal_rd_data_i[11:0]);

    // Top nibble of the palette word carries no colour.
    assign w_unused_pal = &{1'b0, pal_rd_data_i[15:12]};

    rgb444_to_grey u_grey (
        .i_rgb (w_src_rgb),
        .o_y   (w_y)
    );

    // Blank has priority over chroma disable: blanked pixels are always black.
    always_comb begin
        w_s2_rgb = w_src_rgb;
        if (chroma_disable_i) begin
            w_s2_rgb = '{r: w_y, g: w_y, b: w_y};
        end
        if (r_s1_sb.blank) begin
            w_s2_rgb = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_sb    <= c_sb_idle;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_addr  <= in_border_i ? border_idx_i : in_index_i;
            r_s1_sb    <= '{hsync: in_hsync_i, vsync: in_vsync_i, blank: in_blank_i};
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_s2_load) begin
            r_hold_full <= 1'b0;
        end else if (r_s1_valid && !r_hold_full) begin
            r_hold      <= rgb444_t'(pal_rd_data_i[11:0]);
            r_hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_rgb   <= '0;
            r_out_sb    <= c_sb_idle;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_rgb   <= w_s2_rgb;
            r_out_sb    <= r_s1_sb;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign pal_rd_addr_o = r_s1_addr;
    assign out_valid_o   = r_out_valid;
    assign out_r_o       = r_out_rgb.r;
    assign out_g_o       = r_out_rgb.g;
    assign out_b_o       = r_out_rgb.b;
    assign out_hsync_o   = r_out_sb.hsync;
    assign out_vsync_o   = r_out_sb.vsync;
    assign out_blank_o   = r_out_sb.blank;

endmodule
`default_nettype wire

// File: tb/tb_palette_lookup.sv
`default_nettype none
// ============================================================================
// Module      : tb_palette_lookup
// Description : Self-checking bench for palette_lookup. A behavioural palette
//               RAM answers the read port; every accepted pixel pushes its
//               expected output to a queue that is popped on each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_lookup;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  in_index_i = '0;
    logic        in_border_i = 1'b0;
    logic        in_blank_i = 1'b0;
    logic        in_hsync_i = 1'b0;
    logic        in_vsync_i = 1'b0;
    logic [7:0]  border_idx_i = '0;
    logic        chroma_disable_i = 1'b0;
    logic [7:0]  pal_rd_addr_o;
    logic [15:0] pal_rd_data_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [3:0]  out_r_o, out_g_o, out_b_o;
    logic        out_hsync_o, out_vsync_o, out_blank_o;

    logic [15:0] pal_mem [256];
    logic [14:0] sb_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk_i = ~clk_i;

    assign pal_rd_data_i = pal_mem[pal_rd_addr_o];

    palette_lookup #(.RD_LATENCY(1)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_index_i       (in_index_i),
        .in_border_i      (in_border_i),
        .in_blank_i       (in_blank_i),
        .in_hsync_i       (in_hsync_i),
        .in_vsync_i       (in_vsync_i),
        .border_idx_i     (border_idx_i),
        .chroma_disable_i (chroma_disable_i),
        .pal_rd_addr_o    (pal_rd_addr_o),
        .pal_rd_data_i    (pal_rd_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_r_o          (out_r_o),
        .out_g_o          (out_g_o),
        .out_b_o          (out_b_o),
        .out_hsync_o      (out_hsync_o),
        .out_vsync_o      (out_vsync_o),
        .out_blank_o      (out_blank_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {r,g,b,hsync,vsync,blank} for a pixel accepted now.
    function automatic logic [14:0] model(input logic [7:0] idx, input logic brd,
                                          input logic blk, input logic hs, input logic vs);
        logic [7:0]  e;
        logic [11:0] c;
        int          sum;
        logic [3:0]  y;
        e = brd ? border_idx_i : idx;
        c = pal_mem[e][11:0];
        if (chroma_disable_i) begin
            sum = 5 * int'(c[11:8]) + 9 * int'(c[7:4]) + 2 * int'(c[3:0]);
            y   = 4'(sum / 16);
            c   = {y, y, y};
        end
        if (blk) c = 12'h000;
        return {c, hs, vs, blk};
    endfunction

    function automatic logic [14:0] obs_now();
        return {out_r_o, out_g_o, out_b_o, out_hsync_o, out_vsync_o, out_blank_o};
    endfunction

    // Scoreboard: push on accept, pop on transfer (sampled mid-cycle).
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (in_valid_i && in_ready_o)
                sb_q.push_back(model(in_index_i, in_border_i, in_blank_i, in_hsync_i, in_vsync_i));
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0)
                    check_val("sb_unexpected_output", 32'(sb_q.size()), 32'd1);
                else
                    check_val("sb_pixel", 32'(obs_now()), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic send_pix(input logic [7:0] idx, input logic brd, input logic blk,
                            input logic hs, input logic vs);
        in_index_i  = idx;
        in_border_i = brd;
        in_blank_i  = blk;
        in_hsync_i  = hs;
        in_vsync_i  = vs;
        in_valid_i  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (in_ready_o) break;
        end
        if (!in_ready_o) check_val("send_timeout", 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        in_valid_i  = 1'b0;
        in_border_i = 1'b0;
        in_blank_i  = 1'b0;
        in_hsync_i  = 1'b0;
        in_vsync_i  = 1'b0;
    endtask

    task automatic wait_out(output logic [14:0] obs);
        obs = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (out_valid_o && out_ready_i) begin
                obs = obs_now();
                @(posedge clk_i);
                #1;
                return;
            end
        end
        check_val("wait_out_timeout", 32'(out_valid_o), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (sb_q.size() == 0 && !out_valid_o) break;
        end
        check_val(tag, 32'(sb_q.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] obs;
        logic [14:0] held;
        logic [7:0]  a;
        int          cnt;

        for (int i = 0; i < 256; i++) pal_mem[i] = 16'($urandom);
        pal_mem[8'h12] = 16'h0ABC;
        pal_mem[8'h05] = 16'h0F00;
        pal_mem[8'h33] = 16'h0123;
        pal_mem[8'h20] = 16'h0FFF;
        pal_mem[8'h21] = 16'h0F00;
        pal_mem[8'h22] = 16'h000F;
        pal_mem[8'h23] = 16'h0000;
        pal_mem[8'h41] = 16'h0369;

        // Reset state, checked before any clock edge (reset acts asynchronously)
        #2 rst_i = 1'b1;
        #1;
        check_val("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_val("rst_addr",      32'(pal_rd_addr_o), 32'd0);
        check_val("rst_rgb_sync",  32'(obs_now()), 32'({12'h000, 3'b001}));
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Latency: accepted at edge E1, visible after E2
        send_pix(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check_val("lat_addr",        32'(pal_rd_addr_o), 32'h12);
        check_val("lat_not_yet",     32'(out_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        check_val("lat_valid",       32'(out_valid_o), 32'd1);
        check_val("lat_rgb",         32'({out_r_o, out_g_o, out_b_o}), 32'h0ABC);
        drain("lat_drain");

        // Border substitution
        border_idx_i = 8'h05;
        send_pix(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check_val("border_addr", 32'(pal_rd_addr_o), 32'h05);
        wait_out(obs);
        check_val("border_rgb", 32'(obs[14:3]), 32'h0F00);
        drain("border_drain");

        // Blank forces black, sync passes
        send_pix(8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        wait_out(obs);
        check_val("blank_out", 32'(obs), 32'({12'h000, 3'b101}));
        drain("blank_drain");

        // Chroma disable
        chroma_disable_i = 1'b1;
        send_pix(8'h20, 1'b0, 1'b0, 1'b0, 1'b0); idle(); wait_out(obs);
        check_val("grey_fff", 32'(obs[14:3]), 32'h0FFF);
        send_pix(8'h21, 1'b0, 1'b0, 1'b0, 1'b0); idle(); wait_out(obs);
        check_val("grey_f00", 32'(obs[14:3]), 32'h0444);
        send_pix(8'h22, 1'b0, 1'b0, 1'b0, 1'b0); idle(); wait_out(obs);
        check_val("grey_00f", 32'(obs[14:3]), 32'h0111);
        send_pix(8'h23, 1'b0, 1'b0, 1'b0, 1'b0); idle(); wait_out(obs);
        check_val("grey_000", 32'(obs[14:3]), 32'h0000);
        drain("grey_drain");
        chroma_disable_i = 1'b0;

        // 256 back-to-back pixels, no gaps at the output
        fork
            begin
                for (int i = 0; i < 256; i++)
                    send_pix(8'(i), 1'b0, 1'b0, i[0], i[1]);
                idle();
            end
            begin
                cnt = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk_i);
                    if (out_valid_o) break;
                end
                for (int k = 0; k < 256; k++) begin
                    if (k != 0) @(negedge clk_i);
                    if (out_valid_o && out_ready_i) cnt++;
                end
                check_val("stream_nogap", 32'(cnt), 32'd256);
            end
        join
        drain("stream_drain");

        // Back-pressure for 5 clocks with a palette write to the stalled entry
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send_pix(8'(8'h80 + i), 1'b0, 1'b0, i[0], 1'b0);
                idle();
            end
            begin
                repeat (6) @(posedge clk_i);
                #1 out_ready_i = 1'b0;
                @(negedge clk_i);
                check_val("bp_in_ready_low", 32'(in_ready_o), 32'd0);
                a    = pal_rd_addr_o;
                held = obs_now();
                @(posedge clk_i);
                #1 pal_mem[a] = pal_mem[a] ^ 16'h0FFF;
                repeat (3) @(posedge clk_i);
                @(negedge clk_i);
                check_val("bp_addr_held", 32'(pal_rd_addr_o), 32'(a));
                check_val("bp_out_stable", 32'(obs_now()), 32'(held));
                check_val("bp_valid_held", 32'(out_valid_o), 32'd1);
                @(posedge clk_i);
                #1 out_ready_i = 1'b1;
            end
        join
        drain("bp_drain");

        // Reset with two pixels in flight
        send_pix(8'h90, 1'b0, 1'b0, 1'b0, 1'b0);
        send_pix(8'h91, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        #1 rst_i = 1'b1;
        #1;
        check_val("rst_mid_valid", 32'(out_valid_o), 32'd0);
        check_val("rst_mid_blank", 32'(out_blank_o), 32'd1);
        sb_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_post_idle", 32'(out_valid_o), 32'd0);
        send_pix(8'h41, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        wait_out(obs);
        check_val("rst_first_pix", 32'(obs), 32'({12'h369, 3'b010}));
        drain("rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
